// File: rtl/mac_pkg.sv
// Shared types and sizing for the pipelined multiply unit.
// STAGES must divide DATA_W evenly; each stage consumes DATA_W/STAGES multiplier bits.
package mac_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned STAGES  = 4;
  localparam int unsigned RES_W   = 2 * DATA_W;
  localparam int unsigned LATENCY = STAGES;
  localparam int unsigned SLICE_W = DATA_W / STAGES;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [RES_W-1:0]  sum;
  } mac_stage_t;

  // Partial product of a with the idx-th SLICE_W-bit slice of b, aligned to its weight.
  function automatic logic [RES_W-1:0] partial_product(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input int unsigned       idx
  );
    logic [SLICE_W-1:0] slice_s;
    logic [RES_W-1:0]   prod_s;
    slice_s = SLICE_W'(b >> (idx * SLICE_W));
    prod_s  = RES_W'(a) * RES_W'(slice_s);
    return prod_s << (idx * SLICE_W);
  endfunction

endpackage

// File: rtl/mac_if.sv
// Operand/result bundle of the pipelined multiply unit.
interface mac_if;
  import mac_pkg::*;

  logic              enable;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [RES_W-1:0]  result;
  logic              done;

  modport master (output enable, output A, output B, input result, input done);
  modport slave  (input enable, input A, input B, output result, output done);

endinterface

// File: rtl/mac_pp_stage.sv
// One pipeline stage: adds its partial product into the travelling sum and registers it.
module mac_pp_stage
  import mac_pkg::*;
#(
  parameter int unsigned STAGE_IDX = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  mac_stage_t stage_in,
  output mac_stage_t stage_out
);

  mac_stage_t       stage_r;
  logic [RES_W-1:0] pp_s;

  // Partial product for this stage's multiplier slice.
  always_comb begin
    pp_s = partial_product(stage_in.a, stage_in.b, STAGE_IDX);
  end

  // Payload only moves with a valid bit, so idle operand changes never disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r <= '0;
    end else begin
      stage_r.valid <= stage_in.valid;
      if (stage_in.valid) begin
        stage_r.a   <= stage_in.a;
        stage_r.b   <= stage_in.b;
        stage_r.sum <= stage_in.sum + pp_s;
      end
    end
  end

  assign stage_out = stage_r;

endmodule

// File: rtl/mac_pipelined.sv
// Pipelined unsigned multiplier, one launch per cycle, result LATENCY cycles after launch.
// Define MAC_ACCUM_EN to accumulate every completed product into result (wraps mod 2^RES_W).
module mac_pipelined
  import mac_pkg::*;
(
  input logic  clk,
  input logic  rst,
  mac_if.slave bus
);

  mac_stage_t       launch_s;
  mac_stage_t       stage_r [STAGES];
  logic [RES_W-1:0] next_result_s;
  logic [RES_W-1:0] result_r;
  logic             done_r;

  // Operands feed stage 0 directly; its register doubles as the launch register.
  always_comb begin
    launch_s       = '0;
    launch_s.valid = bus.enable;
    launch_s.a     = bus.A;
    launch_s.b     = bus.B;
    launch_s.sum   = '0;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_first
      mac_pp_stage #(.STAGE_IDX(0)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .stage_in  (launch_s),
        .stage_out (stage_r[0])
      );
    end else begin : g_rest
      mac_pp_stage #(.STAGE_IDX(s)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .stage_in  (stage_r[s-1]),
        .stage_out (stage_r[s])
      );
    end
  end

  // In the accumulate build result_r itself is the accumulator.
  always_comb begin
    next_result_s = result_r;
`ifdef MAC_ACCUM_EN
    next_result_s = result_r + stage_r[STAGES-1].sum;
`else
    next_result_s = stage_r[STAGES-1].sum;
`endif
  end

  // Output register: loads only on a completed operation, done pulses for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= stage_r[STAGES-1].valid;
      if (stage_r[STAGES-1].valid) begin
        result_r <= next_result_s;
      end
    end
  end

  assign bus.result = result_r;
  assign bus.done   = done_r;

endmodule

// File: tb/tb_mac_pipelined.sv
// Directed bench for mac_pipelined: latency, done pulse shape, extremes, back-to-back and reset.
module tb_mac_pipelined;
  import mac_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [RES_W-1:0] model_acc;

  always #5 clk = ~clk;

  mac_if bus ();

  mac_pipelined dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected result for a completed product, tracking the accumulator when enabled.
  function automatic logic [RES_W-1:0] exp_res(input logic [RES_W-1:0] prod);
`ifdef MAC_ACCUM_EN
    model_acc = model_acc + prod;
`else
    model_acc = prod;
`endif
    return model_acc;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ops();
    bus.enable = 1'b0;
    bus.A      = 8'($urandom);
    bus.B      = 8'($urandom);
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    bus.enable = 1'b1;
    bus.A      = a;
    bus.B      = b;
    step();
    idle_ops();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    idle_ops();
    for (int i = 0; i < cycles; i++) begin
      step();
      check_val("rst_result", 32'(bus.result), 32'd0);
      check_val("rst_done", 32'(bus.done), 32'd0);
    end
    rst       = 1'b0;
    model_acc = '0;
  endtask

  // Single launch: done low for edges k..k+3, high after k+4, low again after k+5.
  task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b);
    logic [RES_W-1:0] exp;
    exp = exp_res(RES_W'(a) * RES_W'(b));
    launch(a, b);
    check_val({tag, "_done_early"}, 32'(bus.done), 32'd0);
    for (int i = 1; i < 4; i++) begin
      step();
      check_val({tag, "_done_early"}, 32'(bus.done), 32'd0);
    end
    step();
    check_val({tag, "_done"}, 32'(bus.done), 32'd1);
    check_val({tag, "_result"}, 32'(bus.result), 32'(exp));
    step();
    check_val({tag, "_done_fall"}, 32'(bus.done), 32'd0);
    check_val({tag, "_hold"}, 32'(bus.result), 32'(exp));
  endtask

  initial begin
    logic [RES_W-1:0] e1, e2, e3;
    rst       = 1'b1;
    model_acc = '0;
    idle_ops();

    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("idle_done", 32'(bus.done), 32'd0);
    end

    run_one("zero_00", 8'd0, 8'd0);
    run_one("zero_50", 8'd5, 8'd0);
    run_one("zero_05", 8'd0, 8'd5);
    run_one("mid_3x4", 8'd3, 8'd4);
    run_one("mid_15x10", 8'd15, 8'd10);
    run_one("ext_255x1", 8'd255, 8'd1);
    run_one("ext_255x255", 8'd255, 8'd255);
    e1 = model_acc;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("ext_stable", 32'(bus.result), 32'(e1));
      check_val("ext_stable_done", 32'(bus.done), 32'd0);
    end

    e1 = exp_res(16'd12);
    e2 = exp_res(16'd150);
    e3 = exp_res(16'd65025);
    launch(8'd3, 8'd4);
    launch(8'd15, 8'd10);
    launch(8'd255, 8'd255);
    step();
    check_val("b2b_early", 32'(bus.done), 32'd0);
    step();
    check_val("b2b_done1", 32'(bus.done), 32'd1);
    check_val("b2b_res1", 32'(bus.result), 32'(e1));
    step();
    check_val("b2b_done2", 32'(bus.done), 32'd1);
    check_val("b2b_res2", 32'(bus.result), 32'(e2));
    step();
    check_val("b2b_done3", 32'(bus.done), 32'd1);
    check_val("b2b_res3", 32'(bus.result), 32'(e3));
    step();
    check_val("b2b_fall", 32'(bus.done), 32'd0);
    check_val("b2b_hold", 32'(bus.result), 32'(e3));

    launch(8'd15, 8'd10);
    step();
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("flush_done", 32'(bus.done), 32'd0);
      check_val("flush_result", 32'(bus.result), 32'd0);
    end
    run_one("relaunch", 8'd15, 8'd10);

    rst        = 1'b1;
    bus.enable = 1'b1;
    bus.A      = 8'd3;
    bus.B      = 8'd4;
    step();
    rst = 1'b0;
    idle_ops();
    model_acc = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      check_val("rst_en_done", 32'(bus.done), 32'd0);
      check_val("rst_en_result", 32'(bus.result), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_pipelined.md
# mac_pipelined

Pipelined unsigned 8×8 multiply unit, the arithmetic core of the dense vector-vector multiplier datapath. Each cycle with `enable` high launches one operand pair (`A`, `B`) into a fixed-latency pipeline. Four cycles later the 16-bit product appears on `result`, qualified by a one-cycle `done` pulse. The unit accepts one new operation per cycle; an optional accumulate mode turns it into a true MAC.

## Interface
- `DATA_W`, default 8: operand width; `result` is 2·`DATA_W` bits wide.
- `STAGES`, default 4: pipeline depth. `DATA_W` must be divisible by `STAGES`.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: launch strobe; operands are sampled on every rising edge where this is high.
- `A` in 8: unsigned multiplicand.
- `B` in 8: unsigned multiplier.
- `result` out 16: registered product (or accumulator value); holds its value between `done` pulses.
- `done` out 1: registered one-cycle strobe marking a new `result`.

## Operation
- Launch: at a rising edge with `enable`=1 and `rst`=0, register `A`, `B` and a valid bit into stage 0.
- Pipeline: each stage adds its partial product into a running 16-bit sum, handling `DATA_W/STAGES` bits of `B` (2 bits at the defaults).
  - Stage s adds `A·B[2s+1:2s]` shifted left by 2s.
  - Operands and the valid bit travel with the sum.
- Arithmetic is unsigned with no truncation. The maximum product 255·255 = 65025 fits in 16 bits.
- Output: when the last stage's valid bit is set, load `result` with the final sum and set `done`=1. Otherwise `done`=0 and `result` keeps its value.
- Throughput: one launch per cycle. Back-to-back launches produce back-to-back `done` pulses, in launch order.
- `A`/`B` values while `enable`=0 are don't-care and must not disturb in-flight operations.
- Reset: `result`=0, `done`=0, all valid bits cleared, all stage registers zeroed.
- Reset mid-operation: every in-flight operation is discarded and no `done` is issued for it. `enable` on the same edge as `rst` is ignored.

## Timing
- Latency is exactly `STAGES` cycles (4 at the defaults).
  - Launch edge k leads to `result` updated and `done`=1 after edge k+4.
  - `done` falls after edge k+5 unless another launch occurred at edge k+1.
- `done` is never held high across cycles for a single operation. Consumers may `wait(done)` and then relaunch.
- No backpressure or ready signal. The unit always accepts `enable`.
- First launch is possible at the first edge after `rst` deasserts.

## Configuration
- Macro `MAC_ACCUM_EN`:
  - **Defined:** a 16-bit accumulator register adds each completed product. On `done`, `result` = previous accumulator + product, modulo 2^16 (wraps silently). The accumulator clears to 0 only on `rst`.
  - **Undefined:** `result` is the plain product of its own operation and no accumulator exists. This is the default build.
- Latency and `done` timing are identical in both builds.

## Structure
- Package `mac_pkg` holds:
  - `DATA_W`, `STAGES` and `RES_W` = 2·`DATA_W`.
  - `LATENCY` = `STAGES`.
  - A packed stage struct `mac_stage_t` containing `valid`, `a`, `b` and `sum`.
- Sub-module `mac_pp_stage`: one pipeline stage. It takes the incoming stage struct and a stage index parameter, and produces the registered next stage. It is instantiated `STAGES` times in a generate loop.
- Top level holds the launch register, the output register and the optional accumulator.

## Test plan
- **Reset:** hold `rst` for 2 cycles → `result`=0 and `done`=0 during and after reset; no `done` pulse until a launch.
- **Zero operands:** launch A=0,B=0, then A=5,B=0, then A=0,B=5 (each waited on) → `result`=0 each time; `done` high exactly 1 cycle, 4 cycles after its launch.
- **Mid-range:** launch A=3,B=4 → `result`=12 after 4 cycles. Launch A=15,B=10 → `result`=150.
- **Extremes:** launch A=255,B=1 → 255. Launch A=255,B=255 → 65025. `result` stays stable until the next `done`.
- **Back-to-back:** launch 3·4, 15·10 and 255·255 on consecutive cycles → `done` high for 3 consecutive cycles with `result` = 12, 150, 65025.
- **Reset in flight:** launch 15·10, then assert `rst` 2 cycles later → no `done`, `result`=0. A relaunch afterwards gives 150 with normal latency.
- **`MAC_ACCUM_EN` build:** launch 3·4 then 15·10 → `result` = 12, then 162.
